// File: rtl/pcie_defs.sv
// Shared definitions for the pcie egress arbiters: default sizes, FSM encodings
// and the VC index type.
package pcie_defs;
  localparam int NUM_VC = 4;
  localparam int DATA_W = 8;
  localparam int BURST  = 4;
  localparam int VC_W   = 2;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;

  typedef logic [VC_W-1:0] vc_idx_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational 4-way round-robin selector: first set elig bit after rr_ptr,
// wrapping around so rr_ptr itself is considered last.
module rr_pick
  import pcie_defs::*;
(
  input  logic [NUM_VC-1:0] elig,
  input  vc_idx_t           rr_ptr,
  output logic              found,
  output vc_idx_t           next_vc
);
  vc_idx_t cand;

  // Walk from farthest to nearest so the closest eligible VC wins.
  always_comb begin
    found   = 1'b0;
    next_vc = rr_ptr;
    cand    = '0;
    for (int k = NUM_VC; k >= 1; k--) begin
      cand = rr_ptr + VC_W'(k);
      if (elig[cand]) begin
        found   = 1'b1;
        next_vc = cand;
      end
    end
  end
endmodule

// File: rtl/vc_arbiter.sv
// Round-robin, burst-limited scheduler for four VC FIFOs onto one egress word
// path with a 2-cycle pop-to-valid pipeline.
module vc_arbiter #(
  parameter int NUM_VC = pcie_defs::NUM_VC,
  parameter int DATA_W = pcie_defs::DATA_W,
  parameter int BURST  = pcie_defs::BURST
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_VC-1:0]          CONTROL,
  input  logic [NUM_VC-1:0]          fifo_empty,
  input  logic [NUM_VC*DATA_W-1:0]   fifo_data,
  input  logic                       almost_full,
  output logic [NUM_VC-1:0]          pop,
  output logic [DATA_W-1:0]          data_out,
  output logic                       valid_out,
  output logic [pcie_defs::VC_W-1:0] grant,
  output logic                       idle
);
  import pcie_defs::*;

  logic [0:0]                    state;
  vc_idx_t                       rr_ptr, sel_q, pick_ptr, next_vc;
  logic [3:0]                    burst_cnt;
  logic [1:0]                    vld_pipe;
  logic [NUM_VC-1:0]             elig;
  logic [NUM_VC-1:0][DATA_W-1:0] words;
  logic                          found, rotate, serve_pop;

  assign elig  = ~fifo_empty & CONTROL;
  assign words = fifo_data;

  // While serving, the search restarts just after the current owner.
  assign pick_ptr  = (state == SERVE) ? grant : rr_ptr;
  assign rotate    = (state == SERVE) && ((burst_cnt == 4'(BURST)) || !elig[grant]);
  assign serve_pop = (state == SERVE) && !rotate && !almost_full;

  rr_pick u_pick (
    .elig    (elig),
    .rr_ptr  (pick_ptr),
    .found   (found),
    .next_vc (next_vc)
  );

  always_comb begin
    pop = '0;
    if (serve_pop) pop[grant] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      rr_ptr    <= 2'd3;
      grant     <= '0;
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        grant     <= next_vc;
        burst_cnt <= '0;
        state     <= SERVE;
      end
    end else if (rotate) begin
      rr_ptr    <= grant;
      burst_cnt <= '0;
      if (found) grant <= next_vc;
      else       state <= IDLE;
    end else if (serve_pop) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

  // vld_pipe[0]: word presented by the FIFO this cycle; vld_pipe[1]: on data_out.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vld_pipe <= '0;
      sel_q    <= '0;
      data_out <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], serve_pop};
      if (serve_pop)   sel_q    <= grant;
      if (vld_pipe[0]) data_out <= words[sel_q];
    end
  end

  assign valid_out = vld_pipe[1];
  assign idle      = (state == IDLE) && (vld_pipe == '0);
endmodule
